// File: rtl/student_id_receiver.sv
// Assembles an ASCII decimal ID from the UART RX byte stream and checks it against EXPECTED_ID.
// The digits are kept as BCD for the display path. Each frame reports either a match or an error class.
module student_id_receiver #(
  parameter int                  ID_LEN         = 10,
  parameter logic [8*ID_LEN-1:0] EXPECTED_ID    = 80'h32303234333131363638,
  parameter int                  TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  busy,
  output logic [3:0]            digit_count,
  output logic [4*ID_LEN-1:0]   id_bcd,
  output logic                  id_done,
  output logic                  id_match,
  output logic [1:0]            err_code
);

  localparam int BCD_W = 4 * ID_LEN;
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2
  } state_e;

  function automatic logic [BCD_W-1:0] ascii_to_bcd(input logic [8*ID_LEN-1:0] ascii);
    logic [BCD_W-1:0] bcd;
    logic [7:0]       digit;
    bcd = '0;
    for (int i = 0; i < ID_LEN; i++) begin
      digit          = ascii[8*i +: 8] - 8'h30;
      bcd[4*i +: 4]  = digit[3:0];
    end
    return bcd;
  endfunction

  // Slot 0 (first digit received) sits in the most significant nibble.
  function automatic logic [BCD_W-1:0] put_digit(input logic [BCD_W-1:0] bcd,
                                                  input logic [3:0]       slot,
                                                  input logic [3:0]       nibble);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < ID_LEN; i++) begin
      if (4'(i) == slot) begin
        res[4*(ID_LEN-1-i) +: 4] = nibble;
      end
    end
    return res;
  endfunction

  localparam logic [BCD_W-1:0] EXP_BCD   = ascii_to_bcd(EXPECTED_ID);
  localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_SLOT = 4'(ID_LEN - 1);
  localparam state_e           FIRST_NXT = (ID_LEN == 1) ? S_CHECK : S_COLLECT;

  state_e           state_q, state_d;
  logic [3:0]       digit_count_q, digit_count_d;
  logic [BCD_W-1:0] id_bcd_q, id_bcd_d;
  logic             id_done_q, id_done_d;
  logic             id_match_q, id_match_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic is_digit;
  logic id_equal;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign id_equal = (id_bcd_q == EXP_BCD);

  always_comb begin
    state_d       = state_q;
    digit_count_d = digit_count_q;
    id_bcd_d      = id_bcd_q;
    id_done_d     = 1'b0;
    id_match_d    = id_match_q;
    err_code_d    = err_code_q;
    gap_d         = gap_q;

    case (state_q)
      S_IDLE: begin
        // Terminators and junk between frames are ignored; only a digit opens a frame.
        if (rx_valid && is_digit) begin
          id_bcd_d      = put_digit('0, 4'd0, rx_data[3:0]);
          digit_count_d = 4'd1;
          id_match_d    = 1'b0;
          err_code_d    = ERR_NONE;
          gap_d         = '0;
          state_d       = FIRST_NXT;
        end
      end

      S_COLLECT: begin
        // A byte that arrives on the expiry cycle takes priority over the timeout.
        if (rx_valid) begin
          gap_d = '0;
          if (is_digit) begin
            id_bcd_d      = put_digit(id_bcd_q, digit_count_q, rx_data[3:0]);
            digit_count_d = digit_count_q + 4'd1;
            if (digit_count_q == LAST_SLOT) begin
              state_d = S_CHECK;
            end
          end else begin
            err_code_d = ERR_ILLEGAL;
            id_done_d  = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (gap_q == LAST_GAP) begin
          err_code_d = ERR_TIMEOUT;
          id_done_d  = 1'b1;
          gap_d      = '0;
          state_d    = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_CHECK: begin
        id_match_d = id_equal;
        err_code_d = id_equal ? ERR_NONE : ERR_MISMATCH;
        id_done_d  = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      digit_count_q <= '0;
      id_bcd_q      <= '0;
      id_done_q     <= 1'b0;
      id_match_q    <= 1'b0;
      err_code_q    <= ERR_NONE;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      digit_count_q <= digit_count_d;
      id_bcd_q      <= id_bcd_d;
      id_done_q     <= id_done_d;
      id_match_q    <= id_match_d;
      err_code_q    <= err_code_d;
      gap_q         <= gap_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign digit_count = digit_count_q;
  assign id_bcd      = id_bcd_q;
  assign id_done     = id_done_q;
  assign id_match    = id_match_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_student_id_receiver.sv
// Scoreboard bench for student_id_receiver: an expected frame result is queued when a frame is sent.
// It is popped and compared when id_done pulses, and the pulse latency is checked in edges.
module tb_student_id_receiver;

  localparam int ID_LEN  = 10;
  localparam int TIMEOUT = 200;

  logic                 clk;
  logic                 rst;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 busy;
  logic [3:0]           digit_count;
  logic [4*ID_LEN-1:0]  id_bcd;
  logic                 id_done;
  logic                 id_match;
  logic [1:0]           err_code;

  student_id_receiver #(
    .ID_LEN         (ID_LEN),
    .EXPECTED_ID    (80'h32303234333131363638),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .digit_count (digit_count),
    .id_bcd      (id_bcd),
    .id_done     (id_done),
    .id_match    (id_match),
    .err_code    (err_code)
  );

  typedef struct {
    logic        match;
    logic [1:0]  err;
    logic [3:0]  cnt;
    logic [39:0] bcd;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   edge_cnt;
  int   last_samp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every id_done pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (rst && id_done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_match", 64'(id_match), 64'(e.match));
        check("done_err", 64'(err_code), 64'(e.err));
        check("done_cnt", 64'(digit_count), 64'(e.cnt));
        check("done_bcd", 64'(id_bcd), 64'(e.bcd));
        check("done_busy", 64'(busy), 64'd0);
        check("done_lat", 64'(edge_cnt - last_samp), 64'(e.lat));
      end
    end
  end

  // Called at #1 after a posedge; leaves the caller at #1 after a posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    last_samp = edge_cnt;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_str(input logic [79:0] s, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_byte(s[8*(9-i) +: 8], gap);
    end
  endtask

  task automatic push(input logic m, input logic [1:0] e, input logic [3:0] c,
                      input logic [39:0] b, input int lat);
    exp_t x;
    x.match = m;
    x.err   = e;
    x.cnt   = c;
    x.bcd   = b;
    x.lat   = lat;
    exp_q.push_back(x);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    edge_cnt  = 0;
    last_samp = 0;
    rst       = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt", 64'(digit_count), 64'd0);
    check("rst_bcd", 64'(id_bcd), 64'd0);
    check("rst_done", 64'(id_done), 64'd0);
    check("rst_match", 64'(id_match), 64'd0);
    check("rst_err", 64'(err_code), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Correct ID with 100-cycle gaps.
    push(1'b1, 2'd0, 4'd10, 40'h2024311668, 1);
    send_str("2024311668", 10, 100);
    drain(50);

    // Wrong last digit.
    push(1'b0, 2'd1, 4'd10, 40'h2024311669, 1);
    send_str("2024311669", 10, 3);
    drain(50);

    // Illegal character after four digits, then a good frame.
    push(1'b0, 2'd2, 4'd4, 40'h2024000000, 0);
    send_str("2024311668", 4, 2);
    send_byte(8'h41, 5);
    drain(50);
    check("illegal_busy", 64'(busy), 64'd0);
    push(1'b1, 2'd0, 4'd10, 40'h2024311668, 1);
    send_str("2024311668", 10, 2);
    drain(50);

    // Timeout after three digits.
    push(1'b0, 2'd3, 4'd3, 40'h2020000000, TIMEOUT);
    send_str("2024311668", 2, 1);
    send_byte(8'h32, 0);
    drain(2 * TIMEOUT + 20);

    // Byte arriving on the expiry cycle keeps the frame alive.
    push(1'b1, 2'd0, 4'd10, 40'h2024311668, 1);
    send_str("2024311668", 2, 1);
    send_byte(8'h32, TIMEOUT - 1);
    send_byte(8'h34, 0);
    check("expiry_cnt", 64'(digit_count), 64'd4);
    check("expiry_busy", 64'(busy), 64'd1);
    check("expiry_err", 64'(err_code), 64'd0);
    send_byte(8'h33, 1);
    send_byte(8'h31, 1);
    send_byte(8'h31, 1);
    send_byte(8'h36, 1);
    send_byte(8'h36, 1);
    send_byte(8'h38, 1);
    drain(50);

    // Terminators and junk while idle change nothing.
    send_byte(8'h0D, 5);
    send_byte(8'h0A, 5);
    send_byte(8'h20, 5);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_match", 64'(id_match), 64'd1);
    check("idle_err", 64'(err_code), 64'd0);
    check("idle_cnt", 64'(digit_count), 64'd10);
    check("idle_bcd", 64'(id_bcd), 64'h2024311668);

    // Reset in the middle of a frame.
    send_str("2024311668", 5, 4);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_cnt", 64'(digit_count), 64'd0);
    check("arst_bcd", 64'(id_bcd), 64'd0);
    check("arst_match", 64'(id_match), 64'd0);
    check("arst_err", 64'(err_code), 64'd0);
    check("arst_done", 64'(id_done), 64'd0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(1'b1, 2'd0, 4'd10, 40'h2024311668, 1);
    send_str("2024311668", 10, 1);
    drain(50);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
